// File: rtl/price_level_book.sv
// ---------------------------------------------------------------------------
// price_level_book
// Single-side price-level book. Levels are kept sorted best-first with
// explicit valid bits. Each command takes three cycles: IDLE (accept),
// CMP (per-level compare vectors and qty arithmetic are registered) and
// WR (levels, top-of-book, count and event pulses are written).
//
// Ports
//   clkIn          clock
//   rstNIn         synchronous active-low reset
//   cmdValidIn     command valid
//   cmdReadyOut    high only in IDLE; a command is accepted on valid & ready
//   cmdOpIn        0=ADD, 1=REDUCE, 2=CLEAR, 3=reserved (error)
//   priceIn        command price (unsigned)
//   qtyIn          command quantity
//   topValidOut    level 1 holds a valid level
//   topPriceOut    best price, 0 when invalid
//   topQtyOut      best quantity, 0 when invalid
//   levelCountOut  number of valid levels
//   bookUpdOut     pulse: book contents changed
//   dropOut        pulse: ADD discarded (book full, price worse than all)
//   evictOut       pulse: worst level pushed out by an insert
//   errOut         pulse: REDUCE on absent price, or op 3
// ---------------------------------------------------------------------------
module price_level_book #(
  parameter int DEPTH   = 8,
  parameter int PRICE_W = 32,
  parameter int QTY_W   = 32,
  parameter int IS_BUY  = 1
) (
  input  logic                       clkIn,
  input  logic                       rstNIn,
  input  logic                       cmdValidIn,
  output logic                       cmdReadyOut,
  input  logic [1:0]                 cmdOpIn,
  input  logic [PRICE_W-1:0]         priceIn,
  input  logic [QTY_W-1:0]           qtyIn,
  output logic                       topValidOut,
  output logic [PRICE_W-1:0]         topPriceOut,
  output logic [QTY_W-1:0]           topQtyOut,
  output logic [$clog2(DEPTH+1)-1:0] levelCountOut,
  output logic                       bookUpdOut,
  output logic                       dropOut,
  output logic                       evictOut,
  output logic                       errOut
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [1:0] OP_ADD    = 2'd0;
  localparam logic [1:0] OP_REDUCE = 2'd1;
  localparam logic [1:0] OP_CLEAR  = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, WR = 2'd2} state_t;

  state_t               state_r;
  logic [1:0]           opLat_r;
  logic [PRICE_W-1:0]   priceLat_r;
  logic [QTY_W-1:0]     qtyLat_r;

  // Invalid levels always hold price/qty 0, so shifting never needs masking.
  logic [DEPTH-1:0]     lvlValid_r;
  logic [PRICE_W-1:0]   lvlPrice_r [DEPTH];
  logic [QTY_W-1:0]     lvlQty_r   [DEPTH];

  logic [DEPTH-1:0]     matchVec_r, betterVec_r, geVec_r;
  logic [QTY_W-1:0]     sumVec_r   [DEPTH];
  logic [QTY_W-1:0]     diffVec_r  [DEPTH];

  logic [DEPTH-1:0]     match_s, better_s, ge_s;
  logic [QTY_W-1:0]     sum_s      [DEPTH];
  logic [QTY_W-1:0]     diff_s     [DEPTH];

  logic [DEPTH-1:0]     nxtValid_s;
  logic [PRICE_W-1:0]   nxtPrice_s [DEPTH];
  logic [QTY_W-1:0]     nxtQty_s   [DEPTH];
  logic [CNT_W-1:0]     nxtCount_s;
  logic [DEPTH-1:0]     insertHere_s, fromMatch_s;
  logic                 run_s;
  logic                 upd_s, drop_s, evict_s, err_s;

  function automatic logic [QTY_W-1:0] satAdd(input logic [QTY_W-1:0] a,
                                              input logic [QTY_W-1:0] b);
    logic [QTY_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[QTY_W] ? {QTY_W{1'b1}} : s[QTY_W-1:0];
  endfunction

  function automatic logic isBetter(input logic [PRICE_W-1:0] newP,
                                    input logic [PRICE_W-1:0] lvlP);
    return (IS_BUY != 0) ? (newP > lvlP) : (newP < lvlP);
  endfunction

  // Compare stage: per-level match/better flags and saturating/plain qty math.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i]  = lvlValid_r[i] && (lvlPrice_r[i] == priceLat_r);
      better_s[i] = !lvlValid_r[i] || isBetter(priceLat_r, lvlPrice_r[i]);
      ge_s[i]     = (qtyLat_r >= lvlQty_r[i]);
      sum_s[i]    = satAdd(lvlQty_r[i], qtyLat_r);
      diff_s[i]   = lvlQty_r[i] - qtyLat_r;
    end
  end

  // Write stage: next book contents and event pulses from the registered vectors.
  always_comb begin
    nxtValid_s = lvlValid_r;
    nxtPrice_s = lvlPrice_r;
    nxtQty_s   = lvlQty_r;
    upd_s      = 1'b0;
    drop_s     = 1'b0;
    evict_s    = 1'b0;
    err_s      = 1'b0;
    // better is a thermometer (ordered, contiguous book): insert at its first 1.
    insertHere_s = betterVec_r & ~{betterVec_r[DEPTH-2:0], 1'b0};
    // Levels at or below the matched level; these move up on a delete.
    run_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      run_s          = run_s | matchVec_r[i];
      fromMatch_s[i] = run_s;
    end
    case (opLat_r)
      OP_ADD: begin
        if (qtyLat_r == {QTY_W{1'b0}}) begin
          upd_s = 1'b0;
        end else if (|matchVec_r) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (matchVec_r[i]) nxtQty_s[i] = sumVec_r[i];
            else               nxtQty_s[i] = lvlQty_r[i];
          end
          upd_s = 1'b1;
        end else if (|betterVec_r) begin
          for (int i = 1; i < DEPTH; i++) begin
            if (betterVec_r[i] && betterVec_r[i-1]) begin
              nxtValid_s[i] = lvlValid_r[i-1];
              nxtPrice_s[i] = lvlPrice_r[i-1];
              nxtQty_s[i]   = lvlQty_r[i-1];
            end else begin
              nxtValid_s[i] = lvlValid_r[i];
            end
          end
          for (int i = 0; i < DEPTH; i++) begin
            if (insertHere_s[i]) begin
              nxtValid_s[i] = 1'b1;
              nxtPrice_s[i] = priceLat_r;
              nxtQty_s[i]   = qtyLat_r;
            end else begin
              nxtValid_s[i] = nxtValid_s[i];
            end
          end
          evict_s = lvlValid_r[DEPTH-1];
          upd_s   = 1'b1;
        end else begin
          drop_s = 1'b1;
        end
      end
      OP_REDUCE: begin
        if (!(|matchVec_r)) begin
          err_s = 1'b1;
        end else if (|(matchVec_r & geVec_r)) begin
          for (int i = 0; i < DEPTH - 1; i++) begin
            if (fromMatch_s[i]) begin
              nxtValid_s[i] = lvlValid_r[i+1];
              nxtPrice_s[i] = lvlPrice_r[i+1];
              nxtQty_s[i]   = lvlQty_r[i+1];
            end else begin
              nxtValid_s[i] = lvlValid_r[i];
            end
          end
          nxtValid_s[DEPTH-1] = 1'b0;
          nxtPrice_s[DEPTH-1] = {PRICE_W{1'b0}};
          nxtQty_s[DEPTH-1]   = {QTY_W{1'b0}};
          upd_s = 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (matchVec_r[i]) nxtQty_s[i] = diffVec_r[i];
            else               nxtQty_s[i] = lvlQty_r[i];
          end
          upd_s = 1'b1;
        end
      end
      OP_CLEAR: begin
        for (int i = 0; i < DEPTH; i++) begin
          nxtPrice_s[i] = {PRICE_W{1'b0}};
          nxtQty_s[i]   = {QTY_W{1'b0}};
        end
        nxtValid_s = {DEPTH{1'b0}};
        upd_s      = (levelCountOut != {CNT_W{1'b0}});
      end
      default: err_s = 1'b1;
    endcase
    nxtCount_s = {CNT_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      nxtCount_s = nxtCount_s + CNT_W'(nxtValid_s[i]);
    end
  end

  // Command FSM with all book state and registered outputs.
  always_ff @(posedge clkIn) begin
    if (!rstNIn) begin
      state_r       <= IDLE;
      opLat_r       <= 2'd0;
      priceLat_r    <= {PRICE_W{1'b0}};
      qtyLat_r      <= {QTY_W{1'b0}};
      lvlValid_r    <= {DEPTH{1'b0}};
      matchVec_r    <= {DEPTH{1'b0}};
      betterVec_r   <= {DEPTH{1'b0}};
      geVec_r       <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        lvlPrice_r[i] <= {PRICE_W{1'b0}};
        lvlQty_r[i]   <= {QTY_W{1'b0}};
        sumVec_r[i]   <= {QTY_W{1'b0}};
        diffVec_r[i]  <= {QTY_W{1'b0}};
      end
      cmdReadyOut   <= 1'b0;
      topValidOut   <= 1'b0;
      topPriceOut   <= {PRICE_W{1'b0}};
      topQtyOut     <= {QTY_W{1'b0}};
      levelCountOut <= {CNT_W{1'b0}};
      bookUpdOut    <= 1'b0;
      dropOut       <= 1'b0;
      evictOut      <= 1'b0;
      errOut        <= 1'b0;
    end else begin
      bookUpdOut <= 1'b0;
      dropOut    <= 1'b0;
      evictOut   <= 1'b0;
      errOut     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmdValidIn && cmdReadyOut) begin
            opLat_r     <= cmdOpIn;
            priceLat_r  <= priceIn;
            qtyLat_r    <= qtyIn;
            state_r     <= CMP;
            cmdReadyOut <= 1'b0;
          end else begin
            cmdReadyOut <= 1'b1;
          end
        end
        CMP: begin
          matchVec_r  <= match_s;
          betterVec_r <= better_s;
          geVec_r     <= ge_s;
          sumVec_r    <= sum_s;
          diffVec_r   <= diff_s;
          state_r     <= WR;
        end
        WR: begin
          lvlValid_r    <= nxtValid_s;
          lvlPrice_r    <= nxtPrice_s;
          lvlQty_r      <= nxtQty_s;
          topValidOut   <= nxtValid_s[0];
          topPriceOut   <= nxtPrice_s[0];
          topQtyOut     <= nxtQty_s[0];
          levelCountOut <= nxtCount_s;
          bookUpdOut    <= upd_s;
          dropOut       <= drop_s;
          evictOut      <= evict_s;
          errOut        <= err_s;
          state_r       <= IDLE;
          cmdReadyOut   <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          cmdReadyOut <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_price_level_book.sv
// ---------------------------------------------------------------------------
// tb_price_level_book
// Drives one buy-side and one sell-side book (DEPTH=4, QTY_W=8) with the same
// command stream and compares both against a sorted-array reference book.
// ---------------------------------------------------------------------------
module tb_price_level_book;

  localparam int DEPTH = 4;
  localparam int PW    = 16;
  localparam int QW    = 8;

  logic          clkIn = 1'b0;
  logic          rstNIn;
  logic          cmdValidIn;
  logic [1:0]    cmdOpIn;
  logic [PW-1:0] priceIn;
  logic [QW-1:0] qtyIn;

  logic          rdy0, tv0, upd0, drop0, ev0, err0;
  logic [PW-1:0] tp0;
  logic [QW-1:0] tq0;
  logic [2:0]    cnt0;
  logic          rdy1, tv1, upd1, drop1, ev1, err1;
  logic [PW-1:0] tp1;
  logic [QW-1:0] tq1;
  logic [2:0]    cnt1;

  int checkCount = 0;
  int errCount   = 0;

  // Reference book: entries 0..mCnt-1 valid, best first.
  logic [PW-1:0] mP [2][DEPTH];
  logic [QW-1:0] mQ [2][DEPTH];
  int            mCnt [2];

  always #5 clkIn = ~clkIn;

  price_level_book #(.DEPTH(DEPTH), .PRICE_W(PW), .QTY_W(QW), .IS_BUY(1)) dutBuy (
    .clkIn(clkIn), .rstNIn(rstNIn), .cmdValidIn(cmdValidIn), .cmdReadyOut(rdy0),
    .cmdOpIn(cmdOpIn), .priceIn(priceIn), .qtyIn(qtyIn),
    .topValidOut(tv0), .topPriceOut(tp0), .topQtyOut(tq0), .levelCountOut(cnt0),
    .bookUpdOut(upd0), .dropOut(drop0), .evictOut(ev0), .errOut(err0));

  price_level_book #(.DEPTH(DEPTH), .PRICE_W(PW), .QTY_W(QW), .IS_BUY(0)) dutSell (
    .clkIn(clkIn), .rstNIn(rstNIn), .cmdValidIn(cmdValidIn), .cmdReadyOut(rdy1),
    .cmdOpIn(cmdOpIn), .priceIn(priceIn), .qtyIn(qtyIn),
    .topValidOut(tv1), .topPriceOut(tp1), .topQtyOut(tq1), .levelCountOut(cnt1),
    .bookUpdOut(upd1), .dropOut(drop1), .evictOut(ev1), .errOut(err1));

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour; pl = {upd, drop, evict, err}.
  task automatic modelApply(input int s, input logic [1:0] op, input logic [PW-1:0] p,
                            input logic [QW-1:0] q, output logic [3:0] pl);
    int  j;
    int  pos;
    int  sum;
    bit  isBuy;
    isBuy = (s == 0);
    pl = 4'b0000;
    j  = -1;
    for (int i = 0; i < mCnt[s]; i++) if (mP[s][i] == p) j = i;
    case (op)
      2'd0: if (q != 0) begin
        if (j >= 0) begin
          sum = int'(mQ[s][j]) + int'(q);
          mQ[s][j] = (sum > 255) ? 8'd255 : sum[7:0];
          pl[3] = 1'b1;
        end else begin
          pos = mCnt[s];
          for (int i = mCnt[s] - 1; i >= 0; i--)
            if (isBuy ? (p > mP[s][i]) : (p < mP[s][i])) pos = i;
          if (pos >= DEPTH) pl[2] = 1'b1;
          else begin
            if (mCnt[s] == DEPTH) pl[1] = 1'b1;
            else mCnt[s]++;
            for (int i = mCnt[s] - 1; i > pos; i--) begin
              mP[s][i] = mP[s][i-1];
              mQ[s][i] = mQ[s][i-1];
            end
            mP[s][pos] = p;
            mQ[s][pos] = q;
            pl[3] = 1'b1;
          end
        end
      end
      2'd1: begin
        if (j < 0) pl[0] = 1'b1;
        else begin
          if (q >= mQ[s][j]) begin
            for (int i = j; i < mCnt[s] - 1; i++) begin
              mP[s][i] = mP[s][i+1];
              mQ[s][i] = mQ[s][i+1];
            end
            mCnt[s]--;
          end else mQ[s][j] = mQ[s][j] - q;
          pl[3] = 1'b1;
        end
      end
      2'd2: begin
        if (mCnt[s] != 0) pl[3] = 1'b1;
        mCnt[s] = 0;
      end
      default: pl[0] = 1'b1;
    endcase
  endtask

  task automatic checkSide(input int s, input logic [3:0] pl, input string tag);
    logic [3:0]    obsPl;
    logic          tv;
    logic [PW-1:0] tp;
    logic [QW-1:0] tq;
    logic [2:0]    cnt;
    if (s == 0) begin
      obsPl = {upd0, drop0, ev0, err0}; tv = tv0; tp = tp0; tq = tq0; cnt = cnt0;
    end else begin
      obsPl = {upd1, drop1, ev1, err1}; tv = tv1; tp = tp1; tq = tq1; cnt = cnt1;
    end
    checkVal($sformatf("%s.pulses.s%0d", tag, s), 32'(obsPl), 32'(pl));
    checkVal($sformatf("%s.topValid.s%0d", tag, s), 32'(tv), (mCnt[s] > 0) ? 32'd1 : 32'd0);
    checkVal($sformatf("%s.topPrice.s%0d", tag, s), 32'(tp), (mCnt[s] > 0) ? 32'(mP[s][0]) : 32'd0);
    checkVal($sformatf("%s.topQty.s%0d", tag, s), 32'(tq), (mCnt[s] > 0) ? 32'(mQ[s][0]) : 32'd0);
    checkVal($sformatf("%s.count.s%0d", tag, s), 32'(cnt), 32'(mCnt[s]));
  endtask

  task automatic doCmd(input logic [1:0] op, input logic [PW-1:0] p, input logic [QW-1:0] q);
    logic [3:0] pl0, pl1;
    int         waitCnt;
    waitCnt = 0;
    while (!rdy0 && waitCnt < 20) begin
      @(negedge clkIn);
      waitCnt++;
    end
    if (!rdy0) begin
      checkVal("readyTimeout", 32'(rdy0), 32'd1);
      return;
    end
    cmdValidIn = 1'b1; cmdOpIn = op; priceIn = p; qtyIn = q;
    @(posedge clkIn);
    #1;
    // Busy window: scramble inputs and valid, none of it may be taken.
    cmdValidIn = 1'($urandom_range(0, 1));
    cmdOpIn = 2'($urandom); priceIn = 16'($urandom); qtyIn = 8'($urandom);
    modelApply(0, op, p, q, pl0);
    modelApply(1, op, p, q, pl1);
    @(negedge clkIn);
    checkVal("busyReady", 32'(rdy0), 32'd0);
    checkVal("busyPulses", 32'({upd0, drop0, ev0, err0, upd1, drop1, ev1, err1}), 32'd0);
    @(posedge clkIn);
    @(posedge clkIn);
    @(negedge clkIn);
    cmdValidIn = 1'b0;
    checkSide(0, pl0, $sformatf("op%0d.p%0d", op, p));
    checkSide(1, pl1, $sformatf("op%0d.p%0d", op, p));
    checkVal("readyBack", 32'({rdy0, rdy1}), 32'd3);
  endtask

  initial begin
    int r;
    logic [PW-1:0] p;
    logic [QW-1:0] q;
    logic [1:0]    op;
    rstNIn = 1'b0; cmdValidIn = 1'b0; cmdOpIn = 2'd0; priceIn = '0; qtyIn = '0;
    mCnt[0] = 0; mCnt[1] = 0;
    repeat (3) @(negedge clkIn);
    checkSide(0, 4'b0000, "reset");
    checkSide(1, 4'b0000, "reset");
    checkVal("resetReady", 32'(rdy0), 32'd0);
    rstNIn = 1'b1;
    @(negedge clkIn);
    checkVal("readyAfterReset", 32'({rdy0, rdy1}), 32'd3);

    // Directed scenarios
    doCmd(2'd0, 16'd100, 8'd10); doCmd(2'd0, 16'd102, 8'd5); doCmd(2'd0, 16'd101, 8'd7);
    checkVal("buyTop102", 32'(tp0), 32'd102);
    doCmd(2'd0, 16'd101, 8'd3); doCmd(2'd1, 16'd102, 8'd5); doCmd(2'd1, 16'd100, 8'd4);
    doCmd(2'd2, 16'd0, 8'd0);
    doCmd(2'd0, 16'd104, 8'd1); doCmd(2'd0, 16'd103, 8'd1);
    doCmd(2'd0, 16'd102, 8'd1); doCmd(2'd0, 16'd101, 8'd1);
    doCmd(2'd0, 16'd105, 8'd1); doCmd(2'd0, 16'd99, 8'd1);
    doCmd(2'd2, 16'd0, 8'd0);
    doCmd(2'd0, 16'd50, 8'd200); doCmd(2'd0, 16'd50, 8'd100);
    checkVal("satQty", 32'(tq0), 32'd255);
    doCmd(2'd0, 16'd0, 8'd4);    doCmd(2'd0, 16'd60, 8'd0);
    doCmd(2'd1, 16'd77, 8'd1);   doCmd(2'd3, 16'd0, 8'd0);
    doCmd(2'd2, 16'd0, 8'd0);
    doCmd(2'd0, 16'd100, 8'd1); doCmd(2'd0, 16'd98, 8'd1); doCmd(2'd0, 16'd99, 8'd1);
    checkVal("sellTop98", 32'(tp1), 32'd98);
    doCmd(2'd2, 16'd0, 8'd0); doCmd(2'd2, 16'd0, 8'd0);

    // Valid held high: accepts every third cycle
    cmdValidIn = 1'b1; cmdOpIn = 2'd3;
    for (int c = 0; c < 12; c++) begin
      checkVal($sformatf("holdReady.c%0d", c), 32'(rdy0), (c % 3 == 0) ? 32'd1 : 32'd0);
      if (c > 0) checkVal($sformatf("holdErr.c%0d", c), 32'(err0), (c % 3 == 0) ? 32'd1 : 32'd0);
      @(negedge clkIn);
    end
    cmdValidIn = 1'b0;
    @(negedge clkIn);

    // Reset asserted while a command sits in CMP
    doCmd(2'd0, 16'd200, 8'd9);
    cmdValidIn = 1'b1; cmdOpIn = 2'd0; priceIn = 16'd300; qtyIn = 8'd5;
    @(posedge clkIn);
    @(negedge clkIn);
    cmdValidIn = 1'b0; rstNIn = 1'b0;
    mCnt[0] = 0; mCnt[1] = 0;
    @(negedge clkIn);
    checkSide(0, 4'b0000, "midReset");
    checkSide(1, 4'b0000, "midReset");
    rstNIn = 1'b1;
    @(negedge clkIn);
    checkVal("readyPostMidReset", 32'(rdy0), 32'd1);
    repeat (3) begin
      @(negedge clkIn);
      checkSide(0, 4'b0000, "quiet");
    end

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      op = (r < 10) ? 2'd0 : (r < 16) ? 2'd1 : (r < 17) ? 2'd2 : (r < 18) ? 2'd3 : 2'd0;
      r = $urandom_range(0, 15);
      p = (r == 0) ? 16'd0 : (r == 1) ? 16'hFFFF : 16'(100 + $urandom_range(0, 9));
      if (op == 2'd1 && mCnt[n % 2] > 0 && $urandom_range(0, 1) == 1)
        p = mP[n % 2][$urandom_range(0, mCnt[n % 2] - 1)];
      r = $urandom_range(0, 7);
      q = (r == 0) ? 8'd0 : (r < 4) ? 8'($urandom_range(1, 20)) : 8'($urandom);
      doCmd(op, p, q);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
    $finish;
  end

endmodule
